// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, states, mux selects, control word.
// Pure declarations; no timing or flow control of its own.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    // Codes 13..15 are unused and decode to an all-zero control word.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_JALEX   = 4'd12
    } state_e;

    localparam logic [1:0] REGDST_RT     = 2'b00;
    localparam logic [1:0] REGDST_RD     = 2'b01;
    localparam logic [1:0] REGDST_RA     = 2'b10;

    localparam logic [1:0] MEM2REG_ALU   = 2'b00;
    localparam logic [1:0] MEM2REG_MDR   = 2'b01;
    localparam logic [1:0] MEM2REG_PC    = 2'b10;

    localparam logic [1:0] SRCB_B        = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_BR       = 2'b11;

    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT   = 2'b10;

    localparam logic [1:0] PCSRC_ALU     = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP    = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state-to-control-word map; zero latency.
// Only FETCH looks at mem_ready_i, so irWrite/pcWrite pulse once when the fetch completes.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
                ctrl_o.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_BR;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RT;
                ctrl_o.mem_to_reg = MEM2REG_MDR;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RD;
                ctrl_o.mem_to_reg = MEM2REG_ALU;
            end
            S_BEQEX: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RT;
                ctrl_o.mem_to_reg = MEM2REG_ALU;
            end
            S_JEX: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            // Link and jump share one cycle: PC still holds PC+4 when r31 is written.
            S_JALEX: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RA;
                ctrl_o.mem_to_reg = MEM2REG_PC;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS main control FSM: state register, next-state logic and pcEn gate.
// 3-5 cycles per instruction; memReady=0 stalls FETCH/MEMRD/MEMWR with outputs held steady.
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rstN,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       memReady,
    output logic       memRead,
    output logic       memWrite,
    output logic       IorD,
    output logic       irWrite,
    output logic       pcEn,
    output logic       regWrite,
    output logic [1:0] regDst,
    output logic [1:0] memToReg,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic [3:0] state
);

    state_e state_q;
    state_e state_d;
    ctrl_t  dec_ctrl;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    OP_JAL:       state_d = S_JALEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = memReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = memReady ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    mips_ctrl_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (memReady),
        .ctrl_o      (dec_ctrl)
    );

    // Reset must silence FETCH's memRead immediately, so the control word is gated by rstN.
    assign ctrl     = rstN ? dec_ctrl : '0;

    assign memRead  = ctrl.mem_read;
    assign memWrite = ctrl.mem_write;
    assign IorD     = ctrl.i_or_d;
    assign irWrite  = ctrl.ir_write;
    assign pcEn     = ctrl.pc_write | (ctrl.pc_write_cond & zero);
    assign regWrite = ctrl.reg_write;
    assign regDst   = ctrl.reg_dst;
    assign memToReg = ctrl.mem_to_reg;
    assign aluSrcA  = ctrl.alu_src_a;
    assign aluSrcB  = ctrl.alu_src_b;
    assign aluOp    = ctrl.alu_op;
    assign pcSource = ctrl.pc_source;
    assign state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for the multi-cycle MIPS controller; expected words are hand-written per state.
// Word layout: memRead memWrite IorD irWrite pcEn regWrite | regDst memToReg | aluSrcA aluSrcB aluOp pcSource
module tb_mips_multicycle_controller;

    logic       clk = 1'b0;
    logic       rstN;
    logic [5:0] opcode;
    logic       zero;
    logic       memReady;
    logic       memRead, memWrite, IorD, irWrite, pcEn, regWrite, aluSrcA;
    logic [1:0] regDst, memToReg, aluSrcB, aluOp, pcSource;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [16:0] W_FETCH   = 17'b100110_00_00_0_01_00_00;
    localparam logic [16:0] W_FWAIT   = 17'b100000_00_00_0_01_00_00;
    localparam logic [16:0] W_DECODE  = 17'b000000_00_00_0_11_00_00;
    localparam logic [16:0] W_MEMADR  = 17'b000000_00_00_1_10_00_00;
    localparam logic [16:0] W_MEMRD   = 17'b101000_00_00_0_00_00_00;
    localparam logic [16:0] W_MEMWB   = 17'b000001_00_01_0_00_00_00;
    localparam logic [16:0] W_MEMWR   = 17'b011000_00_00_0_00_00_00;
    localparam logic [16:0] W_RTEX    = 17'b000000_00_00_1_00_10_00;
    localparam logic [16:0] W_RTWB    = 17'b000001_01_00_0_00_00_00;
    localparam logic [16:0] W_BEQ_T   = 17'b000010_00_00_1_00_01_01;
    localparam logic [16:0] W_BEQ_NT  = 17'b000000_00_00_1_00_01_01;
    localparam logic [16:0] W_ADDIEX  = 17'b000000_00_00_1_10_00_00;
    localparam logic [16:0] W_ADDIWB  = 17'b000001_00_00_0_00_00_00;
    localparam logic [16:0] W_JEX     = 17'b000010_00_00_0_00_00_10;
    localparam logic [16:0] W_JALEX   = 17'b000011_10_10_0_00_00_10;
    localparam logic [16:0] W_ZERO    = 17'b0;

    logic [16:0] obs_word;
    assign obs_word = {memRead, memWrite, IorD, irWrite, pcEn, regWrite,
                       regDst, memToReg, aluSrcA, aluSrcB, aluOp, pcSource};

    mips_multicycle_controller dut (
        .clk      (clk),
        .rstN     (rstN),
        .opcode   (opcode),
        .zero     (zero),
        .memReady (memReady),
        .memRead  (memRead),
        .memWrite (memWrite),
        .IorD     (IorD),
        .irWrite  (irWrite),
        .pcEn     (pcEn),
        .regWrite (regWrite),
        .regDst   (regDst),
        .memToReg (memToReg),
        .aluSrcA  (aluSrcA),
        .aluSrcB  (aluSrcB),
        .aluOp    (aluOp),
        .pcSource (pcSource),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_word);
        n_checks++;
        assert (state === exp_state) else begin
            n_fail++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state, exp_state);
        end
        n_checks++;
        assert (obs_word === exp_word) else begin
            n_fail++;
            $error("FAIL %s word: observed %b expected %b", tag, obs_word, exp_word);
        end
    endtask

    // Drive inputs mid-low-phase, let combinational outputs settle, then compare.
    task automatic step(input logic [5:0] op, input logic mr, input logic z);
        @(negedge clk);
        opcode   = op;
        memReady = mr;
        zero     = z;
        #1;
    endtask

    initial begin
        rstN     = 1'b1;
        opcode   = 6'b0;
        zero     = 1'b0;
        memReady = 1'b1;
        #2 rstN  = 1'b0;
        #1;
        chk("reset_hold", 4'd0, W_ZERO);

        // Release: first cycle is FETCH with memRead up.
        @(negedge clk);
        rstN = 1'b1;
        #1;
        chk("release_fetch", 4'd0, W_FETCH);

        // R-type: 4 cycles, regWrite/regDst=01 only in cycle 4.
        step(6'b000000, 1'b1, 1'b0); chk("r_decode",  4'd1,  W_DECODE);
        step(6'b000000, 1'b1, 1'b0); chk("r_ex",      4'd6,  W_RTEX);
        step(6'b000000, 1'b1, 1'b0); chk("r_wb",      4'd7,  W_RTWB);

        // lw with a fetch stall and two MEMRD wait cycles.
        step(6'b100011, 1'b0, 1'b0); chk("lw_fwait",  4'd0,  W_FWAIT);
        step(6'b100011, 1'b1, 1'b0); chk("lw_fetch",  4'd0,  W_FETCH);
        step(6'b100011, 1'b1, 1'b0); chk("lw_decode", 4'd1,  W_DECODE);
        step(6'b100011, 1'b1, 1'b0); chk("lw_adr",    4'd2,  W_MEMADR);
        step(6'b100011, 1'b0, 1'b0); chk("lw_rd_w1",  4'd3,  W_MEMRD);
        step(6'b100011, 1'b0, 1'b0); chk("lw_rd_w2",  4'd3,  W_MEMRD);
        step(6'b100011, 1'b1, 1'b0); chk("lw_rd",     4'd3,  W_MEMRD);
        step(6'b100011, 1'b1, 1'b0); chk("lw_wb",     4'd4,  W_MEMWB);

        // sw with one MEMWR wait.
        step(6'b101011, 1'b1, 1'b0); chk("sw_fetch",  4'd0,  W_FETCH);
        step(6'b101011, 1'b1, 1'b0); chk("sw_decode", 4'd1,  W_DECODE);
        step(6'b101011, 1'b1, 1'b0); chk("sw_adr",    4'd2,  W_MEMADR);
        step(6'b101011, 1'b0, 1'b0); chk("sw_wr_w",   4'd5,  W_MEMWR);
        step(6'b101011, 1'b1, 1'b0); chk("sw_wr",     4'd5,  W_MEMWR);

        // beq taken then not taken.
        step(6'b000100, 1'b1, 1'b0); chk("beqt_fetch", 4'd0, W_FETCH);
        step(6'b000100, 1'b1, 1'b0); chk("beqt_dec",   4'd1, W_DECODE);
        step(6'b000100, 1'b1, 1'b1); chk("beq_taken",  4'd8, W_BEQ_T);
        step(6'b000100, 1'b1, 1'b0); chk("beqn_fetch", 4'd0, W_FETCH);
        step(6'b000100, 1'b1, 1'b0); chk("beqn_dec",   4'd1, W_DECODE);
        step(6'b000100, 1'b1, 1'b0); chk("beq_ntaken", 4'd8, W_BEQ_NT);

        // addi.
        step(6'b001000, 1'b1, 1'b0); chk("addi_fetch", 4'd0,  W_FETCH);
        step(6'b001000, 1'b1, 1'b0); chk("addi_dec",   4'd1,  W_DECODE);
        step(6'b001000, 1'b1, 1'b0); chk("addi_ex",    4'd9,  W_ADDIEX);
        step(6'b001000, 1'b1, 1'b0); chk("addi_wb",    4'd10, W_ADDIWB);

        // j and jal.
        step(6'b000010, 1'b1, 1'b0); chk("j_fetch",    4'd0,  W_FETCH);
        step(6'b000010, 1'b1, 1'b0); chk("j_dec",      4'd1,  W_DECODE);
        step(6'b000010, 1'b1, 1'b0); chk("j_ex",       4'd11, W_JEX);
        step(6'b000011, 1'b1, 1'b0); chk("jal_fetch",  4'd0,  W_FETCH);
        step(6'b000011, 1'b1, 1'b0); chk("jal_dec",    4'd1,  W_DECODE);
        step(6'b000011, 1'b1, 1'b0); chk("jal_ex",     4'd12, W_JALEX);

        // Illegal opcode: DECODE returns straight to FETCH, nothing written.
        step(6'b111111, 1'b1, 1'b1); chk("ill_fetch",  4'd0,  W_FETCH);
        step(6'b111111, 1'b1, 1'b1); chk("ill_dec",    4'd1,  W_DECODE);
        step(6'b111111, 1'b0, 1'b1); chk("ill_back",   4'd0,  W_FWAIT);

        // Reset asserted mid-MEMRD wait aborts the load.
        step(6'b100011, 1'b1, 1'b0); chk("rst_fetch",  4'd0,  W_FETCH);
        step(6'b100011, 1'b1, 1'b0); chk("rst_dec",    4'd1,  W_DECODE);
        step(6'b100011, 1'b1, 1'b0); chk("rst_adr",    4'd2,  W_MEMADR);
        step(6'b100011, 1'b0, 1'b0); chk("rst_rd_w",   4'd3,  W_MEMRD);
        #1 rstN = 1'b0;
        #1;
        chk("rst_async", 4'd0, W_ZERO);
        step(6'b100011, 1'b1, 1'b0);
        chk("rst_held", 4'd0, W_ZERO);
        rstN = 1'b1;
        #1;
        chk("rst_release", 4'd0, W_FETCH);
        step(6'b100011, 1'b1, 1'b0); chk("rst_next",   4'd1,  W_DECODE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
